// File: rtl/fpu_operand_unpacker.sv
// Unpacks two IEEE-754 binary32 operands into sign/exponent/significand, class flags and FCLASS masks.
// Optional FPU_UNPACK_SKID_EN adds a one-entry skid buffer so in_ready_o is a registered output.
module fpu_operand_unpacker (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        sign_a_o,
  output logic        sign_b_o,
  output logic [7:0]  exp_a_o,
  output logic [7:0]  exp_b_o,
  output logic [23:0] sig_a_o,
  output logic [23:0] sig_b_o,
  output logic        is_zero_a_o,
  output logic        is_zero_b_o,
  output logic        is_inf_a_o,
  output logic        is_inf_b_o,
  output logic        is_nan_a_o,
  output logic        is_nan_b_o,
  output logic        is_signaling_o,
  output logic [9:0]  class_a_o,
  output logic [9:0]  class_b_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and flush/reset win over any simultaneous transfer.

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic [9:0]  cls;
  } unpacked_t;

  function automatic unpacked_t unpack(input logic [31:0] w);
    unpacked_t u;
    logic e_zero, e_ones, f_zero, norm, sub;
    e_zero = (w[30:23] == 8'h00);
    e_ones = (w[30:23] == 8'hFF);
    f_zero = (w[22:0] == 23'd0);
    norm   = !e_zero && !e_ones;
    sub    = e_zero && !f_zero;
    u.sign = w[31];
    u.exp  = w[30:23];
    u.sig  = {!e_zero, w[22:0]};
    u.zero = e_zero && f_zero;
    u.inf  = e_ones && f_zero;
    u.nan  = e_ones && !f_zero;
    u.snan = u.nan && !w[22];
    // FCLASS bit order, MSB first: qNaN, sNaN, +inf, +norm, +sub, +0, -0, -sub, -norm, -inf
    u.cls  = {u.nan && w[22], u.snan,
              !w[31] && u.inf, !w[31] && norm, !w[31] && sub, !w[31] && u.zero,
              w[31] && u.zero, w[31] && sub, w[31] && norm, w[31] && u.inf};
    return u;
  endfunction

  unpacked_t w_new_a, w_new_b;
  unpacked_t r_out_a, r_out_b;
  logic      r_out_valid;
  logic      w_in_xfer;

  assign w_new_a = unpack(op_a_i);
  assign w_new_b = unpack(op_b_i);

`ifdef FPU_UNPACK_SKID_EN
  unpacked_t r_skid_a, r_skid_b;
  logic      r_skid_valid;
  logic      r_in_ready;
  logic      w_out_xfer;

  assign in_ready_o = r_in_ready;
  assign w_in_xfer  = in_valid_i && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_skid_a     <= '0;
      r_skid_b     <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      // Skid full means upstream is stalled; only a downstream transfer can free it.
      if (w_out_xfer) begin
        r_out_a      <= r_skid_a;
        r_out_b      <= r_skid_b;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_in_xfer) begin
      if (!r_out_valid || out_ready_i) begin
        r_out_a     <= w_new_a;
        r_out_b     <= w_new_b;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_a     <= w_new_a;
        r_skid_b     <= w_new_b;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end
`else
  logic w_in_ready;

  assign w_in_ready = !r_out_valid || out_ready_i;
  assign in_ready_o = w_in_ready;
  assign w_in_xfer  = in_valid_i && w_in_ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_a     <= w_new_a;
      r_out_b     <= w_new_b;
      r_out_valid <= 1'b1;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid_o    = r_out_valid;
  assign sign_a_o       = r_out_a.sign;
  assign sign_b_o       = r_out_b.sign;
  assign exp_a_o        = r_out_a.exp;
  assign exp_b_o        = r_out_b.exp;
  assign sig_a_o        = r_out_a.sig;
  assign sig_b_o        = r_out_b.sig;
  assign is_zero_a_o    = r_out_a.zero;
  assign is_zero_b_o    = r_out_b.zero;
  assign is_inf_a_o     = r_out_a.inf;
  assign is_inf_b_o     = r_out_b.inf;
  assign is_nan_a_o     = r_out_a.nan;
  assign is_nan_b_o     = r_out_b.nan;
  assign is_signaling_o = r_out_a.snan || r_out_b.snan;
  assign class_a_o      = r_out_a.cls;
  assign class_b_o      = r_out_b.cls;

endmodule

// File: tb/tb_fpu_operand_unpacker.sv
// Self-checking bench for fpu_operand_unpacker: directed corner cases plus randomized
// valid/ready/flush traffic scored against an in-flight queue model of the operand pairs.
module tb_fpu_operand_unpacker;

  logic        clk_i;
  logic        reset_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sign_a_o, sign_b_o;
  logic [7:0]  exp_a_o, exp_b_o;
  logic [23:0] sig_a_o, sig_b_o;
  logic        is_zero_a_o, is_zero_b_o;
  logic        is_inf_a_o, is_inf_b_o;
  logic        is_nan_a_o, is_nan_b_o;
  logic        is_signaling_o;
  logic [9:0]  class_a_o, class_b_o;

  int n_cmp = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  logic [63:0] exp_q[$];

  fpu_operand_unpacker dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sign_a_o(sign_a_o), .sign_b_o(sign_b_o),
    .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
    .sig_a_o(sig_a_o), .sig_b_o(sig_b_o),
    .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
    .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
    .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
    .is_signaling_o(is_signaling_o),
    .class_a_o(class_a_o), .class_b_o(class_b_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference: classify by value category, then derive flags and mask from the category index.
  function automatic int ref_class_idx(input logic [31:0] w);
    int e;
    int f;
    e = int'(w[30:23]);
    f = int'(w[22:0]);
    if (e == 255) return (f == 0) ? (w[31] ? 0 : 7) : (w[22] ? 9 : 8);
    if (e == 0)   return (f == 0) ? (w[31] ? 3 : 4) : (w[31] ? 2 : 5);
    return w[31] ? 1 : 6;
  endfunction

  function automatic logic [45:0] ref_fields(input logic [31:0] w);
    int idx;
    logic [9:0]  one;
    logic [23:0] sig;
    idx = ref_class_idx(w);
    one = 10'd1;
    sig = {1'b0, w[22:0]} + ((w[30:23] != 8'd0) ? 24'd8388608 : 24'd0);
    return {w[31], w[30:23], sig, (idx == 3 || idx == 4), (idx == 0 || idx == 7),
            (idx == 8 || idx == 9), one << idx};
  endfunction

  function automatic logic ref_snan(input logic [31:0] w);
    return ref_class_idx(w) == 8;
  endfunction

  function automatic logic model_ready();
`ifdef FPU_UNPACK_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready_i;
`endif
  endfunction

  function automatic logic [45:0] dut_fields_a();
    return {sign_a_o, exp_a_o, sig_a_o, is_zero_a_o, is_inf_a_o, is_nan_a_o, class_a_o};
  endfunction

  function automatic logic [45:0] dut_fields_b();
    return {sign_b_o, exp_b_o, sig_b_o, is_zero_b_o, is_inf_b_o, is_nan_b_o, class_b_o};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 3))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(0, 255));
    endcase
    f = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_fields_a"}, 64'(dut_fields_a()), 64'd0);
    check({tag, "_fields_b"}, 64'(dut_fields_b()), 64'd0);
    check({tag, "_snan"}, 64'(is_signaling_o), 64'd0);
  endtask

  // driver step: compare at negedge, advance the model at the posedge, return #1 after it
  task automatic step(output logic acc);
    logic pop;
    logic [63:0] head;
    @(negedge clk_i);
    check("out_valid", 64'(out_valid_o), 64'(exp_q.size() > 0));
    check("in_ready", 64'(in_ready_o), 64'(model_ready()));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("fields_a", 64'(dut_fields_a()), 64'(ref_fields(head[63:32])));
      check("fields_b", 64'(dut_fields_b()), 64'(ref_fields(head[31:0])));
      check("is_signaling", 64'(is_signaling_o),
            64'(ref_snan(head[63:32]) || ref_snan(head[31:0])));
    end
    acc = in_valid_i && model_ready();
    pop = (exp_q.size() > 0) && out_ready_i;
    @(posedge clk_i);
    if (reset_i || flush_i) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (acc) exp_q.push_back({op_a_i, op_b_i});
    end
    #1;
  endtask

  initial begin
    logic acc;
    int idx;
    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_a_i = 32'd0; op_b_i = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zeroed("reset");
    reset_i = 1'b0;
    check("ready_after_reset", 64'(in_ready_o), 64'd1);
    step(acc);

    // 1.0 and smallest positive subnormal
    op_a_i = 32'h3F800000; op_b_i = 32'h00000001; in_valid_i = 1'b1; out_ready_i = 1'b1;
    step(acc);
    in_valid_i = 1'b0;
    check("d1_valid", 64'(out_valid_o), 64'd1);
    check("d1_sign_a", 64'(sign_a_o), 64'd0);
    check("d1_exp_a", 64'(exp_a_o), 64'h7F);
    check("d1_sig_a", 64'(sig_a_o), 64'h800000);
    check("d1_class_a", 64'(class_a_o), 64'h040);
    check("d1_exp_b", 64'(exp_b_o), 64'h00);
    check("d1_sig_b", 64'(sig_b_o), 64'h000001);
    check("d1_class_b", 64'(class_b_o), 64'h020);
    step(acc);

    // sNaN and negative qNaN
    op_a_i = 32'h7F800001; op_b_i = 32'hFFC00000; in_valid_i = 1'b1;
    step(acc);
    in_valid_i = 1'b0;
    check("d2_nan_a", 64'(is_nan_a_o), 64'd1);
    check("d2_nan_b", 64'(is_nan_b_o), 64'd1);
    check("d2_snan", 64'(is_signaling_o), 64'd1);
    check("d2_class_a", 64'(class_a_o), 64'h100);
    check("d2_class_b", 64'(class_b_o), 64'h200);
    step(acc);

    // -inf and -0
    op_a_i = 32'hFF800000; op_b_i = 32'h80000000; in_valid_i = 1'b1;
    step(acc);
    in_valid_i = 1'b0;
    check("d3_inf_a", 64'(is_inf_a_o), 64'd1);
    check("d3_class_a", 64'(class_a_o), 64'h001);
    check("d3_zero_b", 64'(is_zero_b_o), 64'd1);
    check("d3_class_b", 64'(class_b_o), 64'h008);
    check("d3_snan", 64'(is_signaling_o), 64'd0);
    step(acc);

    // 8 back-to-back pairs with a downstream stall on cycles 3-6
    pop_cnt = 0;
    idx = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      out_ready_i = !(cyc >= 3 && cyc <= 6);
      in_valid_i  = (idx < 8);
      op_a_i = 32'h40000000 + 32'(idx);
      op_b_i = rand_op();
      step(acc);
      if (acc) idx++;
    end
    in_valid_i = 1'b0;
    check("b2b_accepted", 64'(idx), 64'd8);
    check("b2b_emitted", 64'(pop_cnt), 64'd8);

    // flush coinciding with a transfer while one pair is held
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    op_a_i = 32'h3F800000; op_b_i = 32'h40400000;
    step(acc);
    check("flush_held", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1; out_ready_i = 1'b1;
    op_a_i = 32'hC0000000; op_b_i = 32'h7FC00000;
    step(acc);
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_valid", 64'(out_valid_o), 64'd0);
    repeat (3) step(acc);

    // reset while stalled with data held
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op_a_i = rand_op(); op_b_i = rand_op();
      step(acc);
    end
    in_valid_i = 1'b0;
    check("rst_stall_valid", 64'(out_valid_o), 64'd1);
    reset_i = 1'b1;
    step(acc);
    check_zeroed("mid_reset");
    reset_i = 1'b0;
    check("ready_after_mid_reset", 64'(in_ready_o), 64'd1);
    step(acc);

    // randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 29) == 0);
      op_a_i = rand_op(); op_b_i = rand_op();
      step(acc);
    end
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (4) step(acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
